// File: rtl/fp_pkg.sv
// Shared definitions for the 13-bit floating-point format and its converters.
// value = sign * frac * 2^(exp - 8); frac is normalized when bit 7 is set.
// Holds field widths, the fp_to_int state enum and the fp13_t operand struct
// (also used by the FP adder).
package fp_pkg;

   localparam int EXP_W  = 4;
   localparam int FRAC_W = 8;
   localparam int INT_W  = 16;
   localparam int ACC_W  = INT_W + FRAC_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp13_t;

endpackage

// File: rtl/fp_to_int_if.sv
// Handshake bundle for fp_to_int.
// Input side : in_valid/in_ready with operand fields in_sign, in_exp, in_frac.
// Output side: out_valid/out_ready with out_data (signed integer) and out_inexact.
// master = operand producer / result consumer, slave = the converter.
interface fp_to_int_if;
   import fp_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [FRAC_W-1:0] in_frac;
   logic              out_valid;
   logic              out_ready;
   logic [INT_W-1:0]  out_data;
   logic              out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_frac, out_ready,
      input  in_ready, out_valid, out_data, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_frac, out_ready,
      output in_ready, out_valid, out_data, out_inexact
   );

endinterface

// File: rtl/fp_to_int.sv
// Iterative converter from fp13 (sign, 4-bit exp, 8-bit frac) to a 16-bit
// two's-complement integer, one left shift per clock.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - fp_to_int_if.slave (operand in, result out, valid/ready both sides)
// Build option: define FP_TO_INT_ROUND_EN to round half away from zero;
// otherwise the result is truncated toward zero. out_inexact is the same in
// both builds.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SHIFT | shifting acc left once per clock until cnt reaches zero
// OUT   | result held on out_data until out_ready
module fp_to_int
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   fp_to_int_if.slave  bus
);

   localparam logic [EXP_W-1:0] CNT_ONE = 1;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [EXP_W-1:0]  cnt;
   logic              sign_r;
   logic              out_valid_r;
   logic [INT_W-1:0]  out_data_r;
   logic              out_inexact_r;
   logic [INT_W-1:0]  mag;

   // Integer part sits above the binary point at bit FRAC_W; acc[7] is the
   // half bit. Largest magnitude is 32640 (+1 when rounding), so no overflow.
`ifdef FP_TO_INT_ROUND_EN
   assign mag = acc[ACC_W-1:FRAC_W] + {{(INT_W-1){1'b0}}, acc[FRAC_W-1]};
`else
   assign mag = acc[ACC_W-1:FRAC_W];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         sign_r        <= 1'b0;
         out_valid_r   <= 1'b0;
         out_data_r    <= '0;
         out_inexact_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc    <= {{INT_W{1'b0}}, bus.in_frac};
                  cnt    <= bus.in_exp;
                  sign_r <= bus.in_sign;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  acc <= acc << 1;
                  cnt <= cnt - CNT_ONE;
               end else begin
                  out_data_r    <= sign_r ? -mag : mag;
                  out_inexact_r <= |acc[FRAC_W-1:0];
                  out_valid_r   <= 1'b1;
                  state         <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = out_valid_r;
   assign bus.out_data    = out_data_r;
   assign bus.out_inexact = out_inexact_r;

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: directed cases, backpressure, mid-conversion reset and
// randomized operands against an arithmetic reference model.
// Honours FP_TO_INT_ROUND_EN the same way as the design.
module tb_fp_to_int;
   import fp_pkg::*;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   fp_to_int_if bus ();

   fp_to_int dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FP_TO_INT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Value = frac * 2^exp / 256, computed as a real fraction then cut to integer.
   function automatic logic [15:0] ref_data(input fp13_t op);
      int scaled;
      int mag;
      scaled = int'(op.frac) * (1 << op.exp);
      mag    = ROUND ? (scaled + 128) / 256 : scaled / 256;
      if (op.sign) mag = -mag;
      return mag[15:0];
   endfunction

   function automatic logic ref_inexact(input fp13_t op);
      int scaled;
      scaled = int'(op.frac) * (1 << op.exp);
      return (scaled % 256) != 0;
   endfunction

   // Present op, wait for acceptance, scramble the inputs, then check latency
   // and result. Leaves the result pending in OUT (out_valid high).
   task automatic send_and_wait(input fp13_t op, input logic [15:0] want_data,
                                input logic want_inx, input string tag);
      int guard;
      int lat;
      bus.in_sign  = op.sign;
      bus.in_exp   = op.exp;
      bus.in_frac  = op.frac;
      bus.in_valid = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 60) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.in_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sign  = 1'($urandom);
      bus.in_exp   = 4'($urandom);
      bus.in_frac  = 8'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         if (bus.in_ready) begin
            check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
            lat = 40;
         end else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      if (lat < 40) check({tag, "_latency"}, 32'(lat - 1), 32'(op.exp) + 32'd1);
      else          check({tag, "_out_timeout"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"}, 32'(bus.out_data), 32'(want_data));
      check({tag, "_inexact"}, 32'(bus.out_inexact), 32'(want_inx));
   endtask

   task automatic drain(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   function automatic fp13_t mk(input logic s, input logic [3:0] e, input logic [7:0] f);
      fp13_t op;
      op.sign = s;
      op.exp  = e;
      op.frac = f;
      return op;
   endfunction

   initial begin
      fp13_t op;
      fp13_t op2;
      logic [15:0] held;
      n_cmp = 0;
      n_err = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_frac   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_inexact", 32'(bus.out_inexact), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      send_and_wait(mk(1'b0, 4'd8, 8'hC0), 16'h00C0, 1'b0, "e8_c0");
      drain("e8_c0");
      send_and_wait(mk(1'b1, 4'd15, 8'hFF), 16'h8080, 1'b0, "e15_ff");
      drain("e15_ff");
      send_and_wait(mk(1'b1, 4'd7, 8'h83), ROUND ? 16'hFFBE : 16'hFFBF, 1'b1, "e7_83");
      drain("e7_83");
      send_and_wait(mk(1'b0, 4'd0, 8'h80), ROUND ? 16'h0001 : 16'h0000, 1'b1, "e0_80");
      drain("e0_80");
      send_and_wait(mk(1'b1, 4'd3, 8'h00), 16'h0000, 1'b0, "neg_zero");
      drain("neg_zero");

      // Backpressure with a competing operand presented while busy.
      op = mk(1'b0, 4'd10, 8'hA5);
      send_and_wait(op, ref_data(op), ref_inexact(op), "bp");
      held = bus.out_data;
      op2 = mk(1'b1, 4'd5, 8'h9D);
      bus.in_sign  = op2.sign;
      bus.in_exp   = op2.exp;
      bus.in_frac  = op2.frac;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_data", 32'(bus.out_data), 32'(held));
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      drain("bp");
      send_and_wait(op2, ref_data(op2), ref_inexact(op2), "bp_second");
      drain("bp_second");

      // Reset in the middle of a long shift.
      bus.in_sign  = 1'b1;
      bus.in_exp   = 4'd12;
      bus.in_frac  = 8'hF1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_data", 32'(bus.out_data), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      send_and_wait(mk(1'b0, 4'd9, 8'h81), 16'h0102, 1'b0, "post_rst");
      drain("post_rst");

      // Random operands with random consumer stalls.
      for (int k = 0; k < 40; k++) begin
         op = mk(1'($urandom), 4'($urandom), 8'($urandom));
         if ((k % 4) == 0) op.frac = op.frac | 8'h80;
         send_and_wait(op, ref_data(op), ref_inexact(op), "rand");
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         drain("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
